// File: rtl/alu_arbiter_pkg.sv
// Shared opcode, state and payload definitions for the ALU arbiter and its ALU.
package alu_arbiter_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'b000,
        OP_OR      = 3'b001,
        OP_SLT     = 3'b010,
        OP_ADD     = 3'b011,
        OP_SUB     = 3'b100,
        OP_NOR     = 3'b101,
        OP_SLL     = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // One latched operation: everything the ALU needs while it settles.
    typedef struct packed {
        alu_op_e              op;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic [SHAMT_W-1:0]   shamt;
    } alu_req_t;

    // One-hot grant: a lone requester wins, a tie goes to whoever was not served last.
    function automatic logic [NUM_REQ-1:0] pick_grant(input logic [NUM_REQ-1:0] valid,
                                                      input logic last_grant);
        logic [NUM_REQ-1:0] g;
        if (valid == 2'b11) begin
            g = last_grant ? 2'b01 : 2'b10;
        end else begin
            g = valid;
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters and the ALU arbiter.
interface alu_arbiter_if;
    import alu_arbiter_pkg::*;

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*OP_W-1:0]     req_op;
    logic [NUM_REQ*DATA_W-1:0]   req_a;
    logic [NUM_REQ*DATA_W-1:0]   req_b;
    logic [NUM_REQ*SHAMT_W-1:0]  req_shamt;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [NUM_REQ-1:0]          rsp_ready;
    logic [DATA_W-1:0]           rsp_result;
    logic                        rsp_zero;
    logic                        rsp_err;
    logic                        busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_shamt, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU; zero flags operand equality, not a zero result.
module alu
    import alu_arbiter_pkg::*;
(
    input  alu_op_e              op,
    input  logic [DATA_W-1:0]    a,
    input  logic [DATA_W-1:0]    b,
    input  logic [SHAMT_W-1:0]   shamt,
    output logic [DATA_W-1:0]    result_c,
    output logic                 zero_c
);

    // Opcode decode; the illegal opcode yields zero.
    always_comb begin
        result_c = '0;
        zero_c   = (a == b);
        case (op)
            OP_AND:  result_c = a & b;
            OP_OR:   result_c = a | b;
            OP_SLT:  result_c = DATA_W'(a < b);
            OP_ADD:  result_c = a + b;
            OP_SUB:  result_c = a - b;
            OP_NOR:  result_c = ~(a | b);
            OP_SLL:  result_c = b << shamt;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one operation in flight.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    state_e               state;
    logic [CNT_W-1:0]     cnt;
    logic                 last_grant;
    logic                 cur_grant;
    alu_req_t             lat;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]    rsp_result_q;
    logic                 rsp_zero_q;
    logic                 rsp_err_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   grant_c;
    alu_req_t             sel_req_c;
    logic [DATA_W-1:0]    alu_result;
    logic                 alu_zero;

    assign grant_c       = pick_grant(bus.req_valid, last_grant);
    assign bus.req_ready = (state == ST_IDLE && !reset) ? grant_c : '0;

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;

    // Route the granted requester's fields toward the operand latch.
    always_comb begin
        sel_req_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_c[i]) begin
                sel_req_c.op    = alu_op_e'(bus.req_op[i*OP_W +: OP_W]);
                sel_req_c.a     = bus.req_a[i*DATA_W +: DATA_W];
                sel_req_c.b     = bus.req_b[i*DATA_W +: DATA_W];
                sel_req_c.shamt = bus.req_shamt[i*SHAMT_W +: SHAMT_W];
            end
        end
    end

    alu u_alu (
        .op       (lat.op),
        .a        (lat.a),
        .b        (lat.b),
        .shamt    (lat.shamt),
        .result_c (alu_result),
        .zero_c   (alu_zero)
    );

    // Accept -> hold operands steady for SETTLE_CYCLES -> present response until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            cur_grant    <= 1'b0;
            lat          <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|(bus.req_valid & bus.req_ready)) begin
                        lat       <= sel_req_c;
                        cur_grant <= grant_c[1];
                        cnt       <= CNT_W'(SETTLE_CYCLES - 1);
                        state     <= ST_SETTLE;
                        busy_q    <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        rsp_result_q <= alu_result;
                        rsp_zero_q   <= alu_zero;
                        rsp_err_q    <= (lat.op == OP_ILLEGAL);
                        rsp_valid_q  <= NUM_REQ'(1) << cur_grant;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[cur_grant]) begin
                        rsp_valid_q <= '0;
                        last_grant  <= cur_grant;
                        state       <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench: fixed vector table, hand-written corner sequences, random traffic.
module tb_alu_arbiter;

    localparam int unsigned SETTLE = 1;

    typedef struct {
        logic [1:0]  valid;
        logic [2:0]  op0;
        logic [2:0]  op1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [4:0]  sh0;
        logic [4:0]  sh1;
        int          g;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   lg_m;
    vec_t vec [12];

    alu_arbiter_if bus ();

    alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-run safety net.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Spec-level reference for one operation.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        longint unsigned la = longint'(a);
        longint unsigned lb = longint'(b);
        longint unsigned r;
        case (op)
            3'd0:    r = la & lb;
            3'd1:    r = la | lb;
            3'd2:    r = (la < lb) ? 1 : 0;
            3'd3:    r = la + lb;
            3'd4:    r = la + 64'h1_0000_0000 - lb;
            3'd5:    r = ~(la | lb);
            3'd6:    r = lb << sh;
            default: r = 0;
        endcase
        return 32'(r & 64'hFFFF_FFFF);
    endfunction

    task automatic do_reset();
        bus.req_valid = 2'b01;
        reset = 1'b1;
        #1;
        check("reset_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset_result", bus.rsp_result, 32'd0);
        check("reset_zero", 32'(bus.rsp_zero), 32'd0);
        check("reset_err", 32'(bus.rsp_err), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 2'b00;
        reset = 1'b0;
        @(posedge clk); #1;
        lg_m = 1;
    endtask

    // One full transaction; starts and ends just after a rising edge.
    task automatic txn(input vec_t v, input int hold, input string tag);
        logic [1:0] oh;
        int n;
        oh = (v.g == 0) ? 2'b01 : 2'b10;
        bus.req_valid = v.valid;
        bus.req_op    = {v.op1, v.op0};
        bus.req_a     = {v.a1, v.a0};
        bus.req_b     = {v.b1, v.b0};
        bus.req_shamt = {v.sh1, v.sh0};
        #1;
        check({tag, "_grant"}, 32'(bus.req_ready), 32'(oh));
        @(posedge clk); #1;
        bus.req_valid = bus.req_valid & ~oh;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(SETTLE));
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
        check({tag, "_result"}, bus.rsp_result, v.res);
        check({tag, "_zero"}, 32'(bus.rsp_zero), 32'(v.zero));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(v.err));
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = ~oh;
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'(oh));
            check({tag, "_hold_result"}, bus.rsp_result, v.res);
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = oh;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        lg_m = v.g;
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        lg_m   = 1;
        reset  = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_shamt = '0;
        bus.rsp_ready = '0;

        vec[0]  = '{2'b11, 3'd4, 3'd2, 32'd7, 32'd2, 32'd7, 32'd9, 5'd0, 5'd0, 0, 32'd0, 1'b1, 1'b0};
        vec[1]  = '{2'b10, 3'd4, 3'd2, 32'd7, 32'd2, 32'd7, 32'd9, 5'd0, 5'd0, 1, 32'd1, 1'b0, 1'b0};
        vec[2]  = '{2'b01, 3'd3, 3'd0, 32'd5, 32'd0, 32'd3, 32'd0, 5'd0, 5'd0, 0, 32'd8, 1'b0, 1'b0};
        vec[3]  = '{2'b10, 3'd0, 3'd7, 32'd0, 32'd4, 32'd0, 32'd4, 5'd0, 5'd0, 1, 32'd0, 1'b1, 1'b1};
        vec[4]  = '{2'b11, 3'd1, 3'd5, 32'h0000_00F0, 32'd0, 32'h0000_000F, 32'd0, 5'd0, 5'd0,
                    0, 32'h0000_00FF, 1'b0, 1'b0};
        vec[5]  = '{2'b10, 3'd1, 3'd5, 32'h0000_00F0, 32'd0, 32'h0000_000F, 32'd0, 5'd0, 5'd0,
                    1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vec[6]  = '{2'b01, 3'd0, 3'd0, 32'hFF00_FF00, 32'd0, 32'h0FF0_0FF0, 32'd0, 5'd0, 5'd0,
                    0, 32'h0F00_0F00, 1'b0, 1'b0};
        vec[7]  = '{2'b01, 3'd4, 3'd0, 32'd3, 32'd0, 32'd5, 32'd0, 5'd0, 5'd0, 0, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vec[8]  = '{2'b10, 3'd0, 3'd3, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd0, 5'd0, 1, 32'd0, 1'b0, 1'b0};
        vec[9]  = '{2'b01, 3'd2, 3'd0, 32'd9, 32'd0, 32'd2, 32'd0, 5'd0, 5'd0, 0, 32'd0, 1'b0, 1'b0};
        vec[10] = '{2'b01, 3'd6, 3'd0, 32'd0, 32'd0, 32'h8000_0001, 32'd0, 5'd31, 5'd0,
                    0, 32'h8000_0000, 1'b0, 1'b0};
        vec[11] = '{2'b10, 3'd0, 3'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd0, 5'd0, 1, 32'd0, 1'b0, 1'b0};

        // Fixed vectors starting from reset, so the first tie goes to requester 0.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            txn(vec[i], i % 3, $sformatf("vec%0d", i));
        end

        // Both requesters valid throughout: grants must alternate starting with 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            v = '{2'b11, 3'd3, 3'd1, 32'd1, 32'd4, 32'd2, 32'd1, 5'd0, 5'd0,
                  i % 2, (i % 2 == 0) ? 32'd3 : 32'd5, 1'b0, 1'b0};
            txn(v, 0, $sformatf("alt%0d", i));
        end
        bus.req_valid = 2'b00;

        // Response held off for five cycles while the consumer stalls.
        v = '{2'b10, 3'd0, 3'd6, 32'd0, 32'd0, 32'd0, 32'd1, 5'd0, 5'd4, 1, 32'd16, 1'b0, 1'b0};
        txn(v, 5, "stall");

        // Reset in the middle of SETTLE discards the operation.
        bus.req_valid = 2'b01;
        bus.req_op    = {3'd0, 3'd3};
        bus.req_a     = {32'd0, 32'd1};
        bus.req_b     = {32'd0, 32'd2};
        #1;
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy_now", 32'(bus.busy), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        lg_m = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        v = '{2'b11, 3'd3, 3'd3, 32'd10, 32'd1, 32'd20, 32'd1, 5'd0, 5'd0, 0, 32'd30, 1'b0, 1'b0};
        txn(v, 1, "after_abort");
        bus.req_valid = 2'b00;

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  sh;
            v.valid = 2'($urandom_range(1, 3));
            v.op0   = 3'($urandom_range(0, 7));
            v.op1   = 3'($urandom_range(0, 7));
            v.a0    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            v.a1    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            v.b0    = ($urandom_range(0, 3) == 0) ? v.a0 : $urandom;
            v.b1    = ($urandom_range(0, 3) == 0) ? v.a1 : 32'($urandom_range(0, 15));
            v.sh0   = 5'($urandom);
            v.sh1   = 5'($urandom);
            if (v.valid == 2'b01)      v.g = 0;
            else if (v.valid == 2'b10) v.g = 1;
            else                       v.g = (lg_m == 0) ? 1 : 0;
            op = (v.g == 0) ? v.op0 : v.op1;
            a  = (v.g == 0) ? v.a0  : v.a1;
            b  = (v.g == 0) ? v.b0  : v.b1;
            sh = (v.g == 0) ? v.sh0 : v.sh1;
            v.res  = ref_result(op, a, b, sh);
            v.zero = (a == b);
            v.err  = (op == 3'd7);
            txn(v, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
            bus.req_valid = 2'b00;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1: clock cycles operands are held on the ALU before capture; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: operation of requester i accepted this cycle.
REQ-006 req_op  input  6  bits [3i+2:3i]: ALU opcode of requester i.
REQ-007 req_a  input  64  bits [32i+31:32i]: operand r1 of requester i.
REQ-008 req_b  input  64  bits [32i+31:32i]: operand r2 of requester i.
REQ-009 req_shamt  input  10  bits [5i+4:5i]: shift amount of requester i.
REQ-010 rsp_valid  output  2  bit i: response for requester i available.
REQ-011 rsp_ready  input  2  bit i: requester i consumes the response.
REQ-012 rsp_result  output  32  result of the responding transaction.
REQ-013 rsp_zero  output  1  1 when r1 equals r2 for the responding transaction.
REQ-014 rsp_err  output  1  1 when the responding opcode was 3'b111.
REQ-015 busy  output  1  1 whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, RESP.
REQ-017 IDLE: grant SHALL go to the single valid requester, or, if both valid, to the requester not served last (last_grant).
REQ-018 req_ready SHALL be combinational, at most one bit high, and only in IDLE for the granted requester.
REQ-019 Handshake (req_valid[g] & req_ready[g]) SHALL latch op, a, b, shamt of g, latch g, load counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-020 Requesters SHALL hold valid and fields stable until ready; fields are sampled only at handshake.
REQ-021 SETTLE: latched operands SHALL drive the ALU unchanged; counter decrements each cycle; at counter 0 result and zero are captured and state goes to RESP.
REQ-022 Latency: rsp_valid[g] SHALL rise exactly SETTLE_CYCLES cycles after the accepting edge.
REQ-023 RESP: rsp_valid[g] SHALL stay high, with rsp_result/rsp_zero/rsp_err stable, until rsp_ready[g]; then last_grant<=g and state goes to IDLE.
REQ-024 No new request SHALL be accepted outside IDLE; maximum throughput is one operation per SETTLE_CYCLES+2 cycles.
REQ-025 Opcodes: 000 and, 001 or, 010 slt (unsigned), 011 add, 100 sub, 101 nor, 110 r2<<shamt; add/sub wrap modulo 2^32.
REQ-026 Opcode 111 SHALL give rsp_result=0, rsp_err=1, rsp_zero still valid; all other opcodes give rsp_err=0.
REQ-027 rsp_ready on a bit without rsp_valid SHALL be ignored.

Reset
REQ-028 reset SHALL immediately force state IDLE, counter 0, last_grant=1 (requester 0 wins first tie), req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0.
REQ-029 reset during SETTLE or RESP SHALL discard the transaction; no response is ever produced for it.

Structure
REQ-030 Opcode constants (AND, OR, SLT, ADD, SUB, NOR, SLL, ILLEGAL) and FSM state encoding SHALL live in a shared package used by alu and alu_arbiter.
REQ-031 One sub-module SHALL be instantiated: the existing alu, driven from the latched operand registers; clk period SHALL exceed its 7-unit delay.

Verification
REQ-032 req0 add a=5 b=3 -> req_ready[0] pulse, rsp_valid[0] one cycle later, result 8, zero 0.
REQ-033 After reset both valid: req0 sub 7,7 and req1 slt 2,9 -> req0 served first (result 0, zero 1), then req1 (result 1, zero 0).
REQ-034 Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1.
REQ-035 req1 sll b=1 shamt=4, rsp_ready low 5 cycles -> rsp_valid[1] held, result 16 stable, req_ready 0 throughout.
REQ-036 reset asserted during SETTLE -> busy drops immediately, no rsp_valid, next request accepted normally.
REQ-037 op 111 a=4 b=4 -> rsp_err 1, result 0, zero 1.
